// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and encodings for the hazard/forwarding scoreboard.
package hazard_scoreboard_pkg;

  // Default geometry of the in-order pipeline
  localparam int AW_DEF    = 5;
  localparam int DEPTH_DEF = 3;

  // Storage widths of a slot; modules zero-extend their narrower
  // parameterised fields into these so one struct serves every instance.
  localparam int AW_MAX = 8;
  localparam int SW_MAX = 4;

  // Result-availability encodings for id_res_stage
  localparam int RES_EXE = 0;  // ALU result / JAL link ready in EXE register
  localparam int RES_MEM = 1;  // load data ready one stage later

  // Forward select meaning "read the register file"
  localparam int FWD_RF = 0;

  // One in-flight instruction tracked after ID
  typedef struct packed {
    logic              vld;     // slot holds a real instruction
    logic              wr;      // instruction writes the register file
    logic [AW_MAX-1:0] addr;    // destination register
    logic [SW_MAX-1:0] rs_idx;  // first slot index whose stage holds the result
  } slot_t;

endpackage

// File: rtl/hazard_scoreboard_lookup.sv
// Priority search of the scoreboard for a single source operand.
// The youngest matching writer decides: forward from it when its result
// is already in its stage register, otherwise request a stall.
module hz_lookup
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  slot_t [DEPTH-1:0] i_slots,
  input  logic              i_id_valid,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_use,
  output logic [SW-1:0]     o_fwd,
  output logic              o_stall_req
);

  logic              w_live;
  logic              w_hit;
  logic [SW_MAX-1:0] w_hit_idx;
  logic [SW_MAX-1:0] w_hit_rs;

  // Register 0 and unused operands never take part in the search
  assign w_live = i_id_valid && i_use && (i_addr != '0);

  // Scan oldest to youngest so the youngest candidate overwrites the rest,
  // then turn the winner into a forward select or a stall request
  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_hit_rs    = '0;
    o_fwd       = SW'(FWD_RF);
    o_stall_req = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_live && i_slots[k].vld && i_slots[k].wr &&
          (i_slots[k].addr == AW_MAX'(i_addr))) begin
        w_hit     = 1'b1;
        w_hit_idx = SW_MAX'(k);
        w_hit_rs  = i_slots[k].rs_idx;
      end
    end
    if (w_hit) begin
      if (w_hit_idx >= w_hit_rs) begin
        o_fwd = SW'(w_hit_idx + SW_MAX'(1));
      end else begin
        o_stall_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: a shift register of in-flight writers
// from EXE (slot 0) to WB (slot DEPTH-1), searched combinationally for each
// ID source operand. The back end never stalls, so the slots shift every cycle.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SW    = $clog2(DEPTH + 1),
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_wraddr,
  input  logic [SW-1:0] id_res_stage,
  input  logic          flush,
  output logic [SW-1:0] fwd_a,
  output logic [SW-1:0] fwd_b,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);

  slot_t [DEPTH-1:0] r_slots;
  logic  [CW-1:0]    r_stall_cnt;

  logic              w_req_a;
  logic              w_req_b;
  logic              w_load;
  logic  [SW-1:0]    w_res_clamp;
  slot_t             w_new_slot;

  // Operand A search
  hz_lookup #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_lookup_a (
    .i_slots     (r_slots),
    .i_id_valid  (id_valid),
    .i_addr      (id_rs),
    .i_use       (id_use_rs),
    .o_fwd       (fwd_a),
    .o_stall_req (w_req_a)
  );

  // Operand B search
  hz_lookup #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_lookup_b (
    .i_slots     (r_slots),
    .i_id_valid  (id_valid),
    .i_addr      (id_rt),
    .i_use       (id_use_rt),
    .o_fwd       (fwd_b),
    .o_stall_req (w_req_b)
  );

  // A flushed instruction is dead, so it can neither stall nor enter EXE
  assign stall     = (w_req_a | w_req_b) & ~flush;
  assign w_load    = id_valid & ~stall & ~flush;
  assign stall_cnt = r_stall_cnt;

  // Results later than WB are meaningless; pin them to the last slot
  assign w_res_clamp = (id_res_stage > SW'(DEPTH - 1)) ? SW'(DEPTH - 1) : id_res_stage;

  // Build the entry that moves into EXE this cycle (bubble unless issuing)
  always_comb begin
    w_new_slot        = '0;
    w_new_slot.vld    = w_load;
    w_new_slot.wr     = w_load & id_wr_en;
    w_new_slot.addr   = AW_MAX'(id_wraddr);
    w_new_slot.rs_idx = SW_MAX'(w_res_clamp);
  end

  // Advance the pipeline image by one stage every cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_slots <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_slots[k] <= r_slots[k-1];
      end
      r_slots[0] <= w_new_slot;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a DEPTH=3/CW=16 instance for the main
// scenarios and a DEPTH=4/CW=4 instance for long latency and saturation.
// Both share the ID-side stimulus.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wr_en;
  logic [4:0] id_wraddr;
  logic [2:0] id_res;
  logic       flush;

  logic [1:0]  fa1, fb1;
  logic        st1;
  logic [15:0] cnt1;
  logic [2:0]  fa2, fb2;
  logic        st2;
  logic [3:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard #(.AW(5), .DEPTH(3), .CW(16)) u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wr_en     (id_wr_en),
    .id_wraddr    (id_wraddr),
    .id_res_stage (id_res[1:0]),
    .flush        (flush),
    .fwd_a        (fa1),
    .fwd_b        (fb1),
    .stall        (st1),
    .stall_cnt    (cnt1)
  );

  hazard_scoreboard #(.AW(5), .DEPTH(4), .CW(4)) u_dut_d4 (
    .clk          (clk),
    .nrst         (nrst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wr_en     (id_wr_en),
    .id_wraddr    (id_wraddr),
    .id_res_stage (id_res),
    .flush        (flush),
    .fwd_a        (fa2),
    .fwd_b        (fb2),
    .stall        (st2),
    .stall_cnt    (cnt2)
  );

  // ---------------- stimulus table / scoreboard ----------------
  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wr;
    logic [4:0] wa;
    logic [2:0] res;
    logic       fl;
    logic [6:0] exp;  // {stall, fwd_a[2:0], fwd_b[2:0]}
  } step_t;

  step_t      steps[$];
  logic [6:0] exp_q[$];

  function automatic step_t mk(input int v, input int rs, input int rt,
                               input int urs, input int urt, input int wr,
                               input int wa, input int res, input int fl,
                               input int e_st, input int e_fa, input int e_fb);
    step_t s;
    s.v   = 1'(v);
    s.rs  = 5'(rs);
    s.rt  = 5'(rt);
    s.urs = 1'(urs);
    s.urt = 1'(urt);
    s.wr  = 1'(wr);
    s.wa  = 5'(wa);
    s.res = 3'(res);
    s.fl  = 1'(fl);
    s.exp = {1'(e_st), 3'(e_fa), 3'(e_fb)};
    return s;
  endfunction

  function automatic void add_drain();
    for (int i = 0; i < 4; i++) steps.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input step_t s);
    id_valid  = s.v;
    id_rs     = s.rs;
    id_rt     = s.rt;
    id_use_rs = s.urs;
    id_use_rt = s.urt;
    id_wr_en  = s.wr;
    id_wraddr = s.wa;
    id_res    = s.res;
    flush     = s.fl;
  endtask

  task automatic drive_step(input step_t s);
    drive_inputs(s);
    exp_q.push_back(s.exp);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 1'b0;
    drive_inputs(mk(0,0,0,0,0,0,0,0,0, 0,0,0));
    #2;
    n_tests++;
    if ({st1, fa1, fb1, cnt1} !== '0) begin
      n_fail++;
      $display("FAIL reset_d3: got st=%0d fa=%0d fb=%0d cnt=%0d, want all 0", st1, fa1, fb1, cnt1);
    end
    n_tests++;
    if ({st2, fa2, fb2, cnt2} !== '0) begin
      n_fail++;
      $display("FAIL reset_d4: got st=%0d fa=%0d fb=%0d cnt=%0d, want all 0", st2, fa2, fb2, cnt2);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic test_forwarding();
    logic [6:0] exp, got;
    steps.delete();
    // ALU back-to-back
    steps.push_back(mk(1,0,0,0,0,1,3,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,3,0,1,0,0,0,RES_EXE,0, 0,1,0));
    add_drain();
    // distance 2 -> slot 2
    steps.push_back(mk(1,0,0,0,0,1,4,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,20,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,21,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,4,0,1,0,0,0,RES_EXE,0, 0,3,0));
    add_drain();
    // distance 3 -> producer already retired
    steps.push_back(mk(1,0,0,0,0,1,4,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,20,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,21,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,22,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,4,0,1,0,0,0,RES_EXE,0, 0,0,0));
    add_drain();
    // youngest of two writers wins
    steps.push_back(mk(1,0,0,0,0,1,7,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,7,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,7,0,1,0,0,0,RES_EXE,0, 0,1,0));
    add_drain();
    // $0 never forwards or stalls, even after a load to $0
    steps.push_back(mk(1,0,0,0,0,1,0,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,1,1,0,0,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,0,RES_MEM,0, 0,0,0));
    steps.push_back(mk(1,0,0,1,1,0,0,RES_EXE,0, 0,0,0));
    add_drain();
    // rs == rt, use flags and id_valid gating
    steps.push_back(mk(1,0,0,0,0,1,8,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,8,8,1,1,0,0,RES_EXE,0, 0,1,1));
    steps.push_back(mk(1,0,0,0,0,1,8,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,8,8,0,1,0,0,RES_EXE,0, 0,0,1));
    steps.push_back(mk(1,0,0,0,0,1,8,RES_EXE,0, 0,0,0));
    steps.push_back(mk(0,8,8,1,1,0,0,RES_EXE,0, 0,0,0));
    add_drain();
    foreach (steps[i]) begin
      drive_step(steps[i]);
      @(negedge clk);
      got = {st1, 1'b0, fa1, 1'b0, fb1};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL forwarding step %0d: got st=%0d fa=%0d fb=%0d, want st=%0d fa=%0d fb=%0d",
                 i, got[6], got[5:3], got[2:0], exp[6], exp[5:3], exp[2:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [6:0] exp, got;
    steps.delete();
    // lw $5 then add reading $5: one stall, then forward from slot 1
    steps.push_back(mk(1,0,0,0,0,1,5,RES_MEM,0, 0,0,0));
    steps.push_back(mk(1,0,5,0,1,1,6,RES_EXE,0, 1,0,0));
    steps.push_back(mk(1,0,5,0,1,1,6,RES_EXE,0, 0,0,2));
    add_drain();
    // older ready ALU writer is shadowed by a younger load
    steps.push_back(mk(1,0,0,0,0,1,7,RES_EXE,0, 0,0,0));
    steps.push_back(mk(1,0,0,0,0,1,7,RES_MEM,0, 0,0,0));
    steps.push_back(mk(1,7,0,1,0,0,0,RES_EXE,0, 1,0,0));
    steps.push_back(mk(1,7,0,1,0,0,0,RES_EXE,0, 0,2,0));
    add_drain();
    foreach (steps[i]) begin
      drive_step(steps[i]);
      @(negedge clk);
      got = {st1, 1'b0, fa1, 1'b0, fb1};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load_use step %0d: got st=%0d fa=%0d fb=%0d, want st=%0d fa=%0d fb=%0d",
                 i, got[6], got[5:3], got[2:0], exp[6], exp[5:3], exp[2:0]);
      end
      if (i == 2) begin
        n_tests++;
        if (cnt1 !== 16'd1) begin
          n_fail++;
          $display("FAIL load_use_cnt: got %0d, want 1", cnt1);
        end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (cnt1 !== 16'd2) begin
      n_fail++;
      $display("FAIL load_use_cnt_end: got %0d, want 2", cnt1);
    end
  endtask

  task automatic test_flush_reset();
    logic [6:0] exp, got;
    steps.delete();
    // flushed producer never enters the scoreboard
    steps.push_back(mk(1,0,0,0,0,1,9,RES_EXE,1, 0,0,0));
    steps.push_back(mk(1,9,0,1,0,0,0,RES_EXE,0, 0,0,0));
    add_drain();
    // flush during a would-be load-use stall suppresses the stall
    steps.push_back(mk(1,0,0,0,0,1,10,RES_MEM,0, 0,0,0));
    steps.push_back(mk(1,0,10,0,1,0,0,RES_EXE,1, 0,0,0));
    steps.push_back(mk(1,0,10,0,1,0,0,RES_EXE,0, 0,0,2));
    add_drain();
    foreach (steps[i]) begin
      drive_step(steps[i]);
      @(negedge clk);
      got = {st1, 1'b0, fa1, 1'b0, fb1};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL flush step %0d: got st=%0d fa=%0d fb=%0d, want st=%0d fa=%0d fb=%0d",
                 i, got[6], got[5:3], got[2:0], exp[6], exp[5:3], exp[2:0]);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (cnt1 !== 16'd2) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d, want 2", cnt1);
    end
    // reset pulsed while a load-use stall is active
    drive_inputs(mk(1,0,0,0,0,1,11,RES_MEM,0, 0,0,0));
    @(posedge clk); #1;
    drive_inputs(mk(1,11,0,1,0,0,0,RES_EXE,0, 0,0,0));
    @(negedge clk);
    n_tests++;
    if (st1 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_stall: got %0d, want 1", st1);
    end
    #1 nrst = 1'b0;
    #1;
    n_tests++;
    if ({st1, fa1, fb1, cnt1} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d fa=%0d fb=%0d cnt=%0d, want all 0", st1, fa1, fb1, cnt1);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({st1, fa1, fb1} !== '0) begin
      n_fail++;
      $display("FAIL post_reset: got st=%0d fa=%0d fb=%0d, want all 0", st1, fa1, fb1);
    end
    @(posedge clk); #1;
    drive_inputs(mk(0,0,0,0,0,0,0,0,0, 0,0,0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    logic [6:0] exp, got;
    logic [3:0] exp_cnt;
    // fresh counter for the DEPTH=4 / CW=4 instance
    @(negedge clk);
    nrst = 1'b0;
    #1;
    n_tests++;
    if (cnt2 !== 4'd0) begin
      n_fail++;
      $display("FAIL d4_reset_cnt: got %0d, want 0", cnt2);
    end
    nrst = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 4'd0;
    steps.delete();
    // res_stage 7 clamps to 3: three stalls, then forward from slot 3
    steps.push_back(mk(1,0,0,0,0,1,13,7,0, 0,0,0));
    for (int j = 0; j < 3; j++) steps.push_back(mk(1,13,0,1,0,0,0,RES_EXE,0, 1,0,0));
    steps.push_back(mk(1,13,0,1,0,0,0,RES_EXE,0, 0,4,0));
    // res_stage 2 loads used immediately, repeated to saturate the counter
    for (int r = 0; r < 7; r++) begin
      steps.push_back(mk(1,0,0,0,0,1,12,2,0, 0,0,0));
      steps.push_back(mk(1,0,12,0,1,0,0,RES_EXE,0, 1,0,0));
      steps.push_back(mk(1,0,12,0,1,0,0,RES_EXE,0, 1,0,0));
      steps.push_back(mk(1,0,12,0,1,0,0,RES_EXE,0, 0,0,3));
    end
    foreach (steps[i]) begin
      drive_step(steps[i]);
      @(negedge clk);
      got = {st2, fa2, fb2};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL latency step %0d: got st=%0d fa=%0d fb=%0d, want st=%0d fa=%0d fb=%0d",
                 i, got[6], got[5:3], got[2:0], exp[6], exp[5:3], exp[2:0]);
      end
      n_tests++;
      if (cnt2 !== exp_cnt) begin
        n_fail++;
        $display("FAIL stall_cnt_sat step %0d: got %0d, want %0d", i, cnt2, exp_cnt);
      end
      if (exp[6] && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (cnt2 !== 4'd15) begin
      n_fail++;
      $display("FAIL stall_cnt_hold: got %0d, want 15", cnt2);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_reset();
    test_latency();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
